// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl -- six-line prioritised interrupt controller in front of CP0.
//
// Each line is sampled into s_q, with the previous sample kept in s_prev_q.
// Edge-mode lines latch a pending bit on a rising edge. That bit is cleared
// by write-1-to-clear or by EOI. Level-mode lines follow the sample.
//
// A three-state FSM (IDLE / ASSERT / SERVICE) presents the highest-priority
// unmasked pending line as a one-hot request. Bit 5 has the highest priority.
// The FSM records which line CP0 accepted and counts accepts modulo 256.
//
// Optional build macro: IRQ_SYNC_EN. When it is defined, a two-flop
// synchroniser sits in front of s_q. This adds two cycles of input latency.
// -----------------------------------------------------------------------------
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  src,
    input  logic        cp0_req,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [5:0]  hwint
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // One-hot decode of a line index; indices above 5 give no line.
    function automatic logic [5:0] onehot6(input logic [2:0] idx);
        logic [5:0] v;
        v = 6'b000000;
        case (idx)
            3'd0:    v = 6'b000001;
            3'd1:    v = 6'b000010;
            3'd2:    v = 6'b000100;
            3'd3:    v = 6'b001000;
            3'd4:    v = 6'b010000;
            3'd5:    v = 6'b100000;
            default: v = 6'b000000;
        endcase
        return v;
    endfunction

    // Index of the highest set bit; returns 0 when no bit is set.
    function automatic logic [2:0] prio_enc6(input logic [5:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (m[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [5:0] s_in_s;
    logic [5:0] s_q;
    logic [5:0] s_prev_q;
    logic [5:0] mask_q;
    logic [5:0] mask_d;
    logic [5:0] mode_q;
    logic [5:0] mode_d;
    logic [5:0] pending_q;
    logic [5:0] pending_d;
    logic [5:0] rise_s;
    logic [5:0] w1c_s;
    logic [5:0] eoi_clr_s;
    logic [5:0] masked_s;
    logic       eligible_s;
    logic [2:0] sel_s;
    logic       eoi_s;
    state_t     state_q;
    logic [2:0] sel_q;
    logic [2:0] isr_id_q;
    logic [7:0] cnt_q;
    logic [5:0] hwint_q;

`ifdef IRQ_SYNC_EN
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;

    // Two-flop synchroniser for the asynchronous device lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 6'b000000;
            sync2_q <= 6'b000000;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
        end
    end

    assign s_in_s = sync2_q;
`else
    assign s_in_s = src;
`endif

    // Sample the lines and keep the previous sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q      <= 6'b000000;
            s_prev_q <= 6'b000000;
        end else begin
            s_q      <= s_in_s;
            s_prev_q <= s_q;
        end
    end

    assign eoi_s      = we && (addr == 2'd3);
    assign masked_s   = pending_q & mask_q;
    assign eligible_s = |masked_s;
    assign sel_s      = prio_enc6(masked_s);

    // Next-state for MASK and MODE from register writes.
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (we && (addr == 2'd0)) begin
            mask_d = wdata[5:0];
        end else begin
            mask_d = mask_q;
        end
        if (we && (addr == 2'd2)) begin
            mode_d = wdata[5:0];
        end else begin
            mode_d = mode_q;
        end
    end

    // Pending next-state. On edge lines a new edge beats a same-cycle clear.
    // Level lines simply track the sample.
    always_comb begin
        rise_s    = s_q & ~s_prev_q;
        w1c_s     = 6'b000000;
        eoi_clr_s = 6'b000000;
        if (we && (addr == 2'd1)) begin
            w1c_s = wdata[5:0];
        end else begin
            w1c_s = 6'b000000;
        end
        if (eoi_s && (state_q == ST_SERVICE)) begin
            eoi_clr_s = onehot6(isr_id_q);
        end else begin
            eoi_clr_s = 6'b000000;
        end
        pending_d = (mode_q & (rise_s | (pending_q & ~(w1c_s | eoi_clr_s))))
                  | (~mode_q & s_q);
    end

    // Configuration and pending registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= 6'b000000;
            mode_q    <= 6'b000000;
            pending_q <= 6'b000000;
        end else begin
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
        end
    end

    // Request FSM.
    // hwint is registered alongside the state so that it is the one-hot of
    // sel_q exactly while the FSM is in ASSERT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 3'd0;
            isr_id_q <= 3'd0;
            cnt_q    <= 8'd0;
            hwint_q  <= 6'b000000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eligible_s) begin
                        state_q <= ST_ASSERT;
                        sel_q   <= sel_s;
                        hwint_q <= onehot6(sel_s);
                    end else begin
                        hwint_q <= 6'b000000;
                    end
                end
                ST_ASSERT: begin
                    // Re-latch sel every cycle so a higher-priority line preempts.
                    sel_q <= sel_s;
                    if (!eligible_s) begin
                        state_q <= ST_IDLE;
                        hwint_q <= 6'b000000;
                    end else if (cp0_req) begin
                        state_q  <= ST_SERVICE;
                        isr_id_q <= sel_s;
                        cnt_q    <= cnt_q + 8'd1;
                        hwint_q  <= 6'b000000;
                    end else begin
                        hwint_q <= onehot6(sel_s);
                    end
                end
                ST_SERVICE: begin
                    hwint_q <= 6'b000000;
                    if (eoi_s) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_SERVICE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    hwint_q <= 6'b000000;
                end
            endcase
        end
    end

    assign hwint = hwint_q;

    // Register read mux; unused bits read as zero.
    always_comb begin
        rdata = 32'h0000_0000;
        case (addr)
            2'd0:    rdata = {26'd0, mask_q};
            2'd1:    rdata = {26'd0, pending_q};
            2'd2:    rdata = {26'd0, mode_q};
            2'd3:    rdata = {16'd0, cnt_q, 1'b0, isr_id_q, 2'b00, state_q};
            default: rdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter none; all widths fixed.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port src  input  6  raw device interrupt lines, bit 5 highest priority.
REQ-005 SHALL have port cp0_req  input  1  CP0 accepted an interrupt or exception this cycle.
REQ-006 SHALL have port addr  input  2  register select (byte address bits [3:2]).
REQ-007 SHALL have port we  input  1  register write strobe.
REQ-008 SHALL have port wdata  input  32  register write data.
REQ-009 SHALL have port rdata  output  32  register read data, combinational from addr.
REQ-010 SHALL have port hwint  output  6  one-hot interrupt request to CP0.

Function
REQ-011 SHALL sample src into s_q each cycle and keep previous sample s_prev.
REQ-012 SHALL keep per-line MODE bit: 1 = edge, 0 = level.
REQ-013 SHALL, for an edge-mode line, set pending[i] when s_q[i]=1 and s_prev[i]=0; the bit stays set until cleared.
REQ-014 SHALL, for a level-mode line, load pending[i] from s_q[i] every cycle; W1C and EOI have no effect on it.
REQ-015 SHALL give set priority over clear when an edge and a W1C or EOI clear hit the same bit in one cycle.
REQ-016 SHALL decode registers as: 0 MASK (rw, bits 5:0); 1 PENDING (read; write-1-to-clear, edge lines only); 2 MODE (rw, bits 5:0); 3 STATUS (read; any write is EOI).
REQ-017 SHALL read STATUS as {16'b0, cnt[7:0], 1'b0, isr_id[2:0], 2'b0, state[1:0]}; unused bits of other registers read 0.
REQ-018 SHALL define sel as the index of the highest set bit of pending & MASK, with eligible = |(pending & MASK).
REQ-019 SHALL implement state IDLE(0), ASSERT(1), SERVICE(2).
REQ-020 SHALL go IDLE->ASSERT when eligible, and latch sel.
REQ-021 SHALL, in ASSERT, re-latch sel every cycle so that a higher-priority line preempts, and go ASSERT->IDLE when not eligible.
REQ-022 SHALL go ASSERT->SERVICE on cp0_req, latch isr_id <= current sel, and increment cnt modulo 256 (255 wraps to 0).
REQ-023 SHALL ignore cp0_req in IDLE and SERVICE.
REQ-024 SHALL go SERVICE->IDLE on EOI, and clear pending[isr_id] if that line is edge-mode.
REQ-025 SHALL ignore EOI outside SERVICE.
REQ-026 SHALL drive hwint = onehot(sel) only in ASSERT; otherwise hwint = 0.
REQ-027 SHALL, without synchronizer, raise hwint 3 rising edges after src rises: s_q, then pending, then state.

Reset
REQ-028 SHALL on reset clear MASK, MODE, pending, s_q, s_prev, sel, isr_id, and cnt, and enter IDLE.
REQ-029 SHALL on reset drive hwint=0 and rdata per the cleared registers.
REQ-030 SHALL let reset during SERVICE or ASSERT abort to IDLE with no EOI effect.

Configuration
REQ-031 SHALL, with IRQ_SYNC_EN defined, place a 2-flop synchronizer (reset to 0) ahead of s_q, so REQ-027 latency becomes 5 edges.
REQ-032 SHALL, without IRQ_SYNC_EN, sample src directly into s_q.

Verification
REQ-033 SHALL cover: MASK=6'h3F, MODE=6'h3F, pulse src[2] for 1 cycle -> hwint=6'b000100 on 3rd edge (5th with IRQ_SYNC_EN); PENDING reads 0x4.
REQ-034 SHALL cover: in ASSERT on line 2, raise edge on src[4] -> hwint becomes 6'b010000; cp0_req -> STATUS isr_id=4, state=2, cnt=1, hwint=0.
REQ-035 SHALL cover: from SERVICE of line 4, write STATUS -> pending[4] cleared, state IDLE; on the next cycle ASSERT for line 2 with hwint=6'b000100.
REQ-036 SHALL cover: MODE=0, MASK=6'h01, hold src[0]=1 -> hwint=1; write PENDING=1 -> pending[0] stays 1; drop src[0] while in ASSERT -> state returns to IDLE, hwint=0.
REQ-037 SHALL cover: edge on src[3] in the same cycle as W1C of bit 3 -> pending[3]=1; 256 accepts -> cnt reads 0.
REQ-038 SHALL cover: assert reset while in SERVICE -> next cycle state=0, MASK=0, hwint=0, and STATUS reads 0.
